rr_ex_stage: RTL

RR_EX_STAGE -- requirements
Module: rr_ex_stage

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/hazard_detect.sv | 28 ++
 rtl/rr_ex_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RR->EX pipeline boundary.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_BR_FLUSH = 2'd2
    } state_t;

    // Control/identity fields of an EX slot; these are the ones a bubble clears.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ctrl_r;
        logic                  branch;
        logic                  mem_read;
        logic                  reg_write;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{default: '0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the instruction in RR.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                  run_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  rr_valid_i,
    input  logic [REG_ADDR_W-1:0] rr_rs1_i,
    input  logic [REG_ADDR_W-1:0] rr_rs2_i,
    input  logic                  rr_ctrl_r_i,
    input  logic                  rr_branch_i,
    output logic                  lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = (rr_rs1_i == ex_rd_i);
        // rs2 is only read by R-type and branch instructions.
        rs2_hit = (rr_ctrl_r_i || rr_branch_i) && (rr_rs2_i == ex_rd_i);
        lu_o    = run_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != '0)
                  && rr_valid_i && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/rr_ex_stage.sv
// RR->EX pipeline register with load-use stall, branch flush and event counters.
module rr_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rr_valid_i,
    input  logic [REG_ADDR_W-1:0] rr_rs1_i,
    input  logic [REG_ADDR_W-1:0] rr_rs2_i,
    input  logic [REG_ADDR_W-1:0] rr_rd_i,
    input  logic                  rr_ctrl_r_i,
    input  logic                  rr_branch_i,
    input  logic                  rr_mem_read_i,
    input  logic                  rr_reg_write_i,
    input  logic [XLEN-1:0]       rr_op1_i,
    input  logic [XLEN-1:0]       rr_op2_i,
    input  logic [XLEN-1:0]       rr_imm_i,
    input  logic [ALU_OP_W-1:0]   rr_alu_op_i,
    input  logic                  hold_i,
    input  logic                  branch_taken_i,
    output logic                  valid_ex,
    output logic [REG_ADDR_W-1:0] rs1_ex,
    output logic [REG_ADDR_W-1:0] rs2_ex,
    output logic [REG_ADDR_W-1:0] rd_ex,
    output logic                  ctrl_r_ex,
    output logic                  branch_ex,
    output logic                  mem_read_ex,
    output logic                  reg_write_ex,
    output logic [XLEN-1:0]       op1_ex,
    output logic [XLEN-1:0]       op2_ex,
    output logic [XLEN-1:0]       imm_ex,
    output logic [ALU_OP_W-1:0]   alu_op_ex,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [1:0]            dbg_state_o
);

    state_t                state_q, state_d;
    ex_ctrl_t              ctrl_q, ctrl_d;
    logic [XLEN-1:0]       op1_q, op1_d;
    logic [XLEN-1:0]       op2_q, op2_d;
    logic [XLEN-1:0]       imm_q, imm_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  lu;
    logic                  bubble;

    hazard_detect u_hazard_detect (
        .run_i         (state_q == ST_RUN),
        .ex_valid_i    (ctrl_q.valid),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (ctrl_q.rd),
        .rr_valid_i    (rr_valid_i),
        .rr_rs1_i      (rr_rs1_i),
        .rr_rs2_i      (rr_rs2_i),
        .rr_ctrl_r_i   (rr_ctrl_r_i),
        .rr_branch_i   (rr_branch_i),
        .lu_o          (lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold_i) begin
            if (branch_taken_i) begin
                state_d = ST_BR_FLUSH;
            end else if (lu) begin
                state_d = ST_LU_STALL;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // hold wins over everything; a taken branch masks a coincident load-use.
    always_comb begin
        stall_o = hold_i || (!branch_taken_i && lu);
        flush_o = !hold_i && (branch_taken_i || (state_q == ST_BR_FLUSH));
        bubble  = branch_taken_i || (state_q == ST_BR_FLUSH) || lu || !rr_valid_i;
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold_i) begin
            if (bubble) begin
                ctrl_d = BUBBLE_CTRL;
            end else begin
                ctrl_d.valid     = 1'b1;
                ctrl_d.rs1       = rr_rs1_i;
                ctrl_d.rs2       = rr_rs2_i;
                ctrl_d.rd        = rr_rd_i;
                ctrl_d.ctrl_r    = rr_ctrl_r_i;
                ctrl_d.branch    = rr_branch_i;
                ctrl_d.mem_read  = rr_mem_read_i;
                ctrl_d.reg_write = rr_reg_write_i;
                op1_d            = rr_op1_i;
                op2_d            = rr_op2_i;
                imm_d            = rr_imm_i;
                alu_op_d         = rr_alu_op_i;
            end
            if (branch_taken_i && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (!branch_taken_i && lu && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= BUBBLE_CTRL;
            op1_q       <= '0;
            op2_q       <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign valid_ex     = ctrl_q.valid;
    assign rs1_ex       = ctrl_q.rs1;
    assign rs2_ex       = ctrl_q.rs2;
    assign rd_ex        = ctrl_q.rd;
    assign ctrl_r_ex    = ctrl_q.ctrl_r;
    assign branch_ex    = ctrl_q.branch;
    assign mem_read_ex  = ctrl_q.mem_read;
    assign reg_write_ex = ctrl_q.reg_write;
    assign op1_ex       = op1_q;
    assign op2_ex       = op2_q;
    assign imm_ex       = imm_q;
    assign alu_op_ex    = alu_op_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign dbg_state_o  = state_q;

endmodule
